// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants for the mm:ss seven-segment display stage
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment patterns for BCD 0..9, bit order g..a, active-high.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [1:0] D_SEC0 = 2'd0;
  localparam logic [1:0] D_SEC1 = 2'd1;
  localparam logic [1:0] D_MIN0 = 2'd2;
  localparam logic [1:0] D_MIN1 = 2'd3;

endpackage

// File: rtl/bcd_to_ssd.sv
// rtl/bcd_to_ssd.sv - combinational BCD digit to segment decoder, blank above 9
module bcd_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) begin
      seg = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/ssd_display_driver.sv
// rtl/ssd_display_driver.sv - double-buffered two-port multiplexed SSD driver
module ssd_display_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 65536,
  parameter int BLINK_DIV   = 64
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic        load,
  output logic        load_ack,
  input  logic        blank_lead,
  input  logic [3:0]  blink_mask,
  output logic        frame_sync,
  output logic [7:0]  jc,
  output logic [7:0]  jd
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  logic [RW-1:0] ref_cnt;
  logic [BW-1:0] blk_cnt;
  logic          phase;
  logic          blink_on;
  logic [15:0]   pending;
  logic [15:0]   disp;
  logic          pend_vld;

  logic          ref_tc;
  logic          boundary;
  logic          blk_wrap;
  logic [3:0]    jc_bcd;
  logic [3:0]    jd_bcd;
  logic          jc_blank;
  logic          jd_blank;
  logic [6:0]    jc_seg;
  logic [6:0]    jd_seg;

  assign ref_tc   = (ref_cnt == REF_LAST);
  assign boundary = ref_tc && phase;
  assign blk_wrap = (blk_cnt == BLK_LAST);

  // Lane selection: phase 0 shows the units digits, phase 1 the tens digits.
  always_comb begin
    jc_bcd   = disp[3:0];
    jd_bcd   = disp[11:8];
    jc_blank = !blink_on && blink_mask[D_SEC0];
    jd_blank = !blink_on && blink_mask[D_MIN0];
    if (phase) begin
      jc_bcd   = disp[7:4];
      jd_bcd   = disp[15:12];
      jc_blank = !blink_on && blink_mask[D_SEC1];
      jd_blank = (!blink_on && blink_mask[D_MIN1]) || (blank_lead && (disp[15:12] == 4'd0));
    end
  end

  bcd_to_ssd u_dec_jc (
    .bcd (jc_bcd),
    .seg (jc_seg)
  );

  bcd_to_ssd u_dec_jd (
    .bcd (jd_bcd),
    .seg (jd_seg)
  );

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      ref_cnt    <= '0;
      blk_cnt    <= '0;
      phase      <= 1'b0;
      blink_on   <= 1'b1;
      pending    <= 16'h0000;
      disp       <= 16'h0000;
      pend_vld   <= 1'b0;
      load_ack   <= 1'b0;
      frame_sync <= 1'b0;
      jc         <= 8'h00;
      jd         <= 8'h00;
    end else begin
      ref_cnt    <= ref_tc ? '0 : ref_cnt + RW'(1);
      frame_sync <= boundary;
      load_ack   <= load;
      if (ref_tc) begin
        phase <= ~phase;
      end
      if (boundary) begin
        blk_cnt <= blk_wrap ? '0 : blk_cnt + BW'(1);
        if (blk_wrap) begin
          blink_on <= ~blink_on;
        end
      end
      // A load landing on the boundary cycle stays pending; disp takes the older word.
      if (boundary && pend_vld) begin
        disp <= pending;
      end
      if (load) begin
        pending  <= digits_in;
        pend_vld <= 1'b1;
      end else if (boundary) begin
        pend_vld <= 1'b0;
      end
      jc <= {phase, jc_blank ? SEG_BLANK : jc_seg};
      jd <= {phase, jd_blank ? SEG_BLANK : jd_seg};
    end
  end

endmodule
